rca_word_sequencer: RTL and testbench

//   Multi-cycle add/subtract controller that computes a WIDTH-bit result by sequencing
//   one external 8-bit ripple-carry slice byte by byte, LSB byte first.

---
 rtl/rca_word_sequencer.sv | 149 ++++++++++++++
 tb/tb_rca_word_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_word_sequencer.sv
// Word-wide add/subtract built from one shared external 8-bit ripple-carry slice,
// walked LSB byte first with the inter-byte carry held in a register.
module rca_word_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             ready,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic [7:0]       slice_a,
  output logic [7:0]       slice_b,
  output logic             slice_cin,
  input  logic [7:0]       slice_sum,
  input  logic             slice_cout,
  input  logic             slice_ovf,
  output logic [1:0]       dbg_state
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [7:0]       byte_a;
  logic [7:0]       byte_b;
  logic             last_byte;

  // Byte selection of the latched operands for the current index.
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDXW'(i)) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end
  end

  assign last_byte = (idx_q == IDXW'(NBYTES - 1));

  // b_q already holds ~B for subtraction, and carry_q starts at 1, so the
  // slice always adds: A + ~B + 1 == A - B.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = operand_a;
          b_d     = sub ? ~operand_b : operand_b;
          carry_d = sub;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDXW'(i)) begin
            result_d[8*i +: 8] = slice_sum;
          end
        end
        carry_d = slice_cout;
        idx_d   = idx_q + IDXW'(1);
        if (last_byte) begin
          carry_out_d = slice_cout;
          overflow_d  = slice_ovf;
          zero_d      = (result_d == '0);
          idx_d       = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  // The slice sees nothing outside RUN so it stays quiet between operations.
  assign slice_a      = (state_q == ST_RUN) ? byte_a  : 8'h00;
  assign slice_b      = (state_q == ST_RUN) ? byte_b  : 8'h00;
  assign slice_cin    = (state_q == ST_RUN) ? carry_q : 1'b0;

  assign ready        = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;
  assign carry_out    = carry_out_q;
  assign overflow     = overflow_q;
  assign zero         = zero_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Bench for rca_word_sequencer: behavioural 8-bit slice, directed steps, result scoreboard.
module tb_rca_word_sequencer;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic          sub;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          ready;
  logic          result_valid;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;
  logic          zero;
  logic [7:0]    slice_a;
  logic [7:0]    slice_b;
  logic          slice_cin;
  logic [7:0]    slice_sum;
  logic          slice_cout;
  logic          slice_ovf;
  logic [1:0]    dbg_state;

  // {carry_out, overflow, zero, result}
  logic [W+2:0]  exp_q[$];
  int            chk_cnt = 0;
  int            err_cnt = 0;

  logic [8:0]    sl_full;
  logic [7:0]    sl_low;

  rca_word_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .sub(sub),
    .operand_a(operand_a), .operand_b(operand_b),
    .ready(ready), .result_valid(result_valid), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout), .slice_ovf(slice_ovf),
    .dbg_state(dbg_state)
  );

  // Behavioural ripple-carry slice.
  assign sl_full    = {1'b0, slice_a} + {1'b0, slice_b} + {8'h00, slice_cin};
  assign sl_low     = {1'b0, slice_a[6:0]} + {1'b0, slice_b[6:0]} + {7'h00, slice_cin};
  assign slice_sum  = sl_full[7:0];
  assign slice_cout = sl_full[8];
  assign slice_ovf  = sl_low[7] ^ sl_full[8];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+2:0] model(input logic s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W-1:0] res;
    logic         ovf;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    res  = full[W-1:0];
    ovf  = (a[W-1] == bb[W-1]) && (res[W-1] != a[W-1]);
    return {full[W], ovf, (res == '0), res};
  endfunction

  // Scoreboard: compare every result_valid cycle against the oldest expectation.
  always @(negedge clock) begin
    logic [W+2:0] e;
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(result_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result",    64'(result),    64'(e[W-1:0]));
        check("zero",      64'(zero),      64'(e[W]));
        check("overflow",  64'(overflow),  64'(e[W+1]));
        check("carry_out", 64'(carry_out), 64'(e[W+2]));
      end
    end
  end

  logic [7:0] exp_sa [4];
  logic       exp_cin[4];

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", 64'(ready), 64'd1);
  endtask

  // Issue one operation, then watch latency, ready and optionally the slice feed.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic chk_slice);
    wait_ready();
    start     = 1'b1;
    sub       = s;
    operand_a = a;
    operand_b = b;
    exp_q.push_back(model(s, a, b));
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      if (k == 0) begin
        start     = 1'b0;
        sub       = ~s;
        operand_a = $urandom;
        operand_b = $urandom;
      end
      check("busy_ready", 64'(ready), 64'd0);
      check("valid_timing", 64'(result_valid), (k == 4) ? 64'd1 : 64'd0);
      if (chk_slice && k < 4) begin
        check("slice_a_seq", 64'(slice_a), 64'(exp_sa[k]));
        check("slice_cin_seq", 64'(slice_cin), 64'(exp_cin[k]));
      end
    end
    @(negedge clock);
    check("ready_return", 64'(ready), 64'd1);
  endtask

  initial begin
    int last;
    int cyc;
    int accepts;
    logic s;
    logic [W-1:0] a;
    logic [W-1:0] b;

    reset     = 1'b1;
    start     = 1'b0;
    sub       = 1'b0;
    operand_a = '0;
    operand_b = '0;
    exp_sa    = '{8'hFF, 8'h00, 8'h00, 8'h00};
    exp_cin   = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({carry_out, overflow, zero}), 64'd0);
    check("rst_slice", 64'({slice_a, slice_b, slice_cin}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic add with slice sequence and latency checks
    run_op(1'b0, 32'h000000FF, 32'h00000001, 1'b1);
    check("idle_slice", 64'({slice_a, slice_b, slice_cin}), 64'd0);

    // Subtraction corners
    run_op(1'b1, 32'h00000000, 32'h00000001, 1'b0);
    run_op(1'b1, 32'h80000000, 32'h00000001, 1'b0);
    run_op(1'b1, 32'h12345678, 32'h00000000, 1'b0);

    // Addition corners
    run_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0);

    // start held high: accepts only in IDLE, operands churn every cycle
    wait_ready();
    start   = 1'b1;
    last    = -1;
    cyc     = 0;
    accepts = 0;
    while (accepts < 3 && cyc < 40) begin
      if (ready === 1'b1) begin
        if (last >= 0) check("accept_gap", 64'(cyc - last), 64'd6);
        last = cyc;
        s = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        sub       = s;
        operand_a = a;
        operand_b = b;
        exp_q.push_back(model(s, a, b));
        accepts++;
      end else begin
        sub       = 1'($urandom_range(0, 1));
        operand_a = $urandom;
        operand_b = $urandom;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check("held_accepts", 64'(accepts), 64'd3);
    repeat (6) @(negedge clock);
    check("held_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of an operation (idx==2)
    wait_ready();
    start     = 1'b1;
    sub       = 1'b0;
    operand_a = 32'h12345678;
    operand_b = 32'h11111111;
    repeat (3) @(negedge clock);
    start = 1'b0;
    check("abort_slice_byte2", 64'(slice_a), 64'h34);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_valid", 64'(result_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_flags", 64'({carry_out, overflow, zero}), 64'd0);
    repeat (6) begin
      @(negedge clock);
      check("abort_no_valid", 64'(result_valid), 64'd0);
    end
    run_op(1'b0, 32'h01010101, 32'h01010101, 1'b0);

    // A few random operations
    repeat (6) begin
      run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    end

    repeat (2) @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
